// File: rtl/reg_write_arbiter.sv
// Round-robin write sequencer that shares one external load-enabled register
// among four requesters: grant, one-cycle write, one-cycle ack, optional gap.
module reg_write_arbiter #(
  parameter int WIDTH = 4,
  parameter int GAP   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           req,
  input  logic [4*WIDTH-1:0]   din,
  output logic                 load,
  output logic [WIDTH-1:0]     d_out,
  output logic [3:0]           gnt,
  output logic [3:0]           ack,
  output logic                 busy,
  output logic [1:0]           last_id,
  output logic [7:0]           wr_count
);

  // Handshake: req[i] is a level held until ack[i] is seen; ack[i] is a single
  // cycle pulse after the write cycle, and req[i] drops in the cycle after it.
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_ACK, S_GAP} state_t;

  state_t     state, state_next;
  logic [3:0] gap_cnt;
  logic [1:0] cur_id;
  logic [1:0] winner;
  logic [1:0] idx;

  // Scan from lowest to highest priority so the highest-priority hit wins.
  always_comb begin
    winner = last_id;
    idx    = last_id;
    for (int k = 4; k >= 1; k--) begin
      idx = last_id + 2'(k);
      if (req[idx]) winner = idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (req != 4'b0000) state_next = S_WRITE;
      S_WRITE: state_next = S_ACK;
      S_ACK:   state_next = (GAP == 0) ? S_IDLE : S_GAP;
      S_GAP:   if (gap_cnt == 4'd1) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load     <= 1'b0;
      d_out    <= '0;
      gnt      <= 4'b0000;
      ack      <= 4'b0000;
      busy     <= 1'b0;
      last_id  <= 2'd3;
      wr_count <= 8'd0;
      gap_cnt  <= 4'd0;
      cur_id   <= 2'd0;
    end else begin
      busy <= (state_next != S_IDLE);
      case (state)
        S_IDLE: begin
          if (req != 4'b0000) begin
            gnt    <= 4'b0001 << winner;
            d_out  <= din[winner*WIDTH +: WIDTH];
            load   <= 1'b1;
            cur_id <= winner;
          end
        end
        S_WRITE: begin
          load     <= 1'b0;
          gnt      <= 4'b0000;
          ack      <= 4'b0001 << cur_id;
          last_id  <= cur_id;
          wr_count <= wr_count + 8'd1;
        end
        S_ACK: begin
          ack <= 4'b0000;
          if (GAP != 0) gap_cnt <= 4'(GAP);
        end
        S_GAP: gap_cnt <= gap_cnt - 4'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed steps plus random traffic, checked
// against a transaction-level model (time since grant, rotating priority).
module tb_reg_write_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [15:0] din = 16'h0000;
  logic        load;
  logic [3:0]  d_out;
  logic [3:0]  gnt, ack;
  logic        busy;
  logic [1:0]  last_id;
  logic [7:0]  wr_count;

  logic [3:0]  req2 = 4'b0000;
  logic [15:0] din2 = 16'h0000;
  logic        load_g;
  logic [3:0]  d_out_g;
  logic [3:0]  gnt_g, ack_g;
  logic        busy_g;
  logic [1:0]  last_id_g;
  logic [7:0]  wr_count_g;

  always #5 clk = ~clk;

  reg_write_arbiter #(.WIDTH(4), .GAP(0)) dut (
    .clk(clk), .rst(rst), .req(req), .din(din), .load(load), .d_out(d_out),
    .gnt(gnt), .ack(ack), .busy(busy), .last_id(last_id), .wr_count(wr_count)
  );

  reg_write_arbiter #(.WIDTH(4), .GAP(2)) dut_g (
    .clk(clk), .rst(rst), .req(req2), .din(din2), .load(load_g), .d_out(d_out_g),
    .gnt(gnt_g), .ack(ack_g), .busy(busy_g), .last_id(last_id_g), .wr_count(wr_count_g)
  );

  // The shared register that the arbiter writes.
  logic [3:0] q = 4'h0;
  always @(posedge clk) if (load) q <= d_out;

  int checks = 0;
  int errors = 0;

  int         m_since = -1;
  int         m_id    = 0;
  int         m_last  = 3;
  int         m_count = 0;
  logic [3:0] m_data  = 4'h0;
  logic [3:0] exp_q[$];
  logic       prev_load = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_since = -1; m_id = 0; m_last = 3; m_count = 0; m_data = 4'h0;
    exp_q.delete();
    prev_load = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_load", load, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_last_id", last_id, 3);
    chk("rst_d_out", d_out, 0);
    chk("rst_wr_count", wr_count, 0);
    chk("rst_g_load", load_g, 0);
    chk("rst_g_last_id", last_id_g, 3);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One clock: model consumes the inputs present at the edge, then outputs are compared.
  task automatic step();
    logic [3:0]  r;
    logic [15:0] dd;
    int          w;
    r = req; dd = din; w = -1;
    @(posedge clk);
    if (m_since < 0) begin
      if (r != 4'b0000) begin
        for (int k = 1; k <= 4; k++)
          if (w < 0 && r[(m_last + k) % 4]) w = (m_last + k) % 4;
        m_id = w;
        m_data = 4'(dd >> (4 * w));
        m_since = 0;
        exp_q.push_back(m_data);
      end
    end else begin
      m_since++;
      if (m_since == 1) begin
        m_last = m_id;
        m_count = (m_count + 1) % 256;
      end
      if (m_since == 2) m_since = -1;
    end
    #1;
    chk("load", load, (m_since == 0) ? 1 : 0);
    chk("gnt", gnt, (m_since == 0) ? (1 << m_id) : 0);
    chk("ack", ack, (m_since == 1) ? (1 << m_id) : 0);
    chk("busy", busy, (m_since >= 0) ? 1 : 0);
    chk("d_out", d_out, m_data);
    chk("last_id", last_id, m_last);
    chk("wr_count", wr_count, m_count);
    if (m_since == 1) chk("reg_q", q, exp_q.pop_front());
    chk("load_back_to_back", load & prev_load, 0);
    prev_load = load;
  endtask

  initial begin
    int ids[$];
    int load_steps[$];
    int busy_n;
    int n_acks;

    // Idle after reset.
    do_reset();
    for (int n = 0; n < 10; n++) step();

    // Single request on requester 0.
    din = 16'h000A; req = 4'b0001;
    step();
    chk("single_gnt", gnt, 4'b0001);
    step();
    chk("single_ack", ack, 4'b0001);
    chk("single_q", q, 4'hA);
    req = 4'b0000;
    step();
    chk("single_busy_low", busy, 0);
    step();

    // All four held: rotation 0,1,2,3,0.
    do_reset();
    din = 16'h4321; req = 4'b1111;
    ids.delete();
    for (int n = 0; n < 15; n++) begin
      step();
      for (int i = 0; i < 4; i++) if (gnt[i]) ids.push_back(i);
    end
    chk("rot_count", ids.size(), 5);
    for (int n = 0; n < ids.size() && n < 5; n++) chk("rot_order", ids[n], n % 4);
    req = 4'b0000;
    step(); step(); step();

    // Fairness: last_id=1, req=1011 -> 3,0,1.
    do_reset();
    din = 16'h9876; req = 4'b0010;
    step(); step();
    req = 4'b0000;
    step();
    chk("fair_last_id", last_id, 1);
    req = 4'b1011;
    ids.delete();
    for (int n = 0; n < 9; n++) begin
      step();
      for (int i = 0; i < 4; i++) if (gnt[i]) ids.push_back(i);
    end
    chk("fair_count", ids.size(), 3);
    if (ids.size() == 3) begin
      chk("fair_0", ids[0], 3);
      chk("fair_1", ids[1], 0);
      chk("fair_2", ids[2], 1);
    end
    req = 4'b0000;
    step(); step(); step();

    // GAP=2 instance: loads 5 cycles apart, busy 4 of 5.
    do_reset();
    din2 = 16'h0007; req2 = 4'b0001;
    load_steps.delete();
    busy_n = 0;
    for (int n = 1; n <= 21; n++) begin
      step();
      if (load_g) load_steps.push_back(n);
      if (n >= 6 && n <= 10 && busy_g) busy_n++;
    end
    chk("gap_loads", load_steps.size(), 5);
    for (int n = 0; n < load_steps.size(); n++) chk("gap_spacing", load_steps[n], 1 + 5 * n);
    chk("gap_busy", busy_n, 4);
    req2 = 4'b0000;

    // Drop req and change din during WRITE.
    do_reset();
    din = 16'h0500; req = 4'b0100;
    step();
    req = 4'b0000; din = 16'($urandom);
    step();
    chk("drop_ack", ack, 4'b0100);
    chk("drop_q", q, 4'h5);
    step(); step();

    // Reset mid-WRITE, held req re-served from requester 0.
    do_reset();
    din = 16'h00C3; req = 4'b0101;
    step(); step(); step();
    step();
    chk("mid_load_before", load, 1);
    do_reset();
    step();
    chk("mid_regrant", gnt, 4'b0001);
    step();
    req = 4'b0000;
    step(); step();

    // Random traffic obeying the requester protocol.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      step();
      din = 16'($urandom);
      for (int i = 0; i < 4; i++) begin
        if (req[i] && ack[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 2) == 0) req[i] = 1'b1;
      end
    end
    req = 4'b0000;
    step(); step(); step();

    // 256 writes wrap the counter.
    do_reset();
    din = 16'h0003; req = 4'b0001;
    n_acks = 0;
    for (int n = 0; n < 900 && n_acks < 256; n++) begin
      step();
      if (ack[0]) n_acks++;
    end
    chk("wrap_acks", n_acks, 256);
    chk("wrap_count", wr_count, 0);
    req = 4'b0000;
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
